// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared constants and the decoded control bundle for the
// RV32I(M) pipelined control unit.
//   - opcode, ALU-op, immediate-select, write-back-select and store-width codes
//   - ctrl_t: everything the decoder produces and the ID/EX register holds
//   - alu_base(): funct3 -> ALU op for the OP / OP-IMM families
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_XOR   = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_AND   = 5'd4;
   localparam logic [4:0] ALU_SLL   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_SLTU  = 5'd8;
   localparam logic [4:0] ALU_SLT   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;
   localparam logic [4:0] ALU_MUL   = 5'd16;  // MUL..REMU = 16 + funct3

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;
   localparam logic [2:0] IMM_R = 3'd5;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] W_SW = 2'd0;
   localparam logic [1:0] W_SH = 2'd1;
   localparam logic [1:0] W_SB = 2'd2;

   typedef struct packed {
      logic [2:0] imm_sel;
      logic       reg_wen;
      logic       br_un;
      logic       a_sel;
      logic       b_sel;
      logic [4:0] alu_sel;
      logic       mem_rw;
      logic       mem_rd;
      logic [1:0] wb_sel;
      logic [2:0] r_sel;
      logic [1:0] w_sel;
      logic [4:0] rd;
      logic       illegal;
      logic       is_jal;   // resolved in EX
      logic       is_jalr;
      logic       is_br;
      logic [2:0] funct3;   // branch condition, only meaningful with is_br
   } ctrl_t;

   // SUB is chosen by the caller (R-type only); sra picks SRA over SRL.
   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic sra);
      logic [4:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = sra ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// rv_ctrl_decode: purely combinational RV32I(M) instruction -> control bundle.
//   inst      in  32  instruction word
//   ctrl      out     decoded bundle (all zero except illegal for bad encodings)
//   rs1/rs2   out  5  source register fields for hazard detection
//   uses_rs2  out  1  instruction reads rs2 (R / STORE / BRANCH)
module rv_ctrl_decode
   import rv_ctrl_pkg::*;
#(
   parameter bit EN_MUL = 1'b0
) (
   input  logic [31:0] inst,
   output ctrl_t       ctrl,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        uses_rs2
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];
   assign rd  = inst[11:7];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign uses_rs2 = (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

   // Opcodes are matched on all 7 bits, so inst[1:0] != 2'b11 lands in default.
   always_comb begin
      ctrl = '0;
      case (opc)
         OPC_R: begin
            ctrl.imm_sel = IMM_R;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.rd      = rd;
            if (f7 == 7'b0000000)
               ctrl.alu_sel = alu_base(f3, 1'b0);
            else if (f7 == 7'b0100000 && f3 == 3'b000)
               ctrl.alu_sel = ALU_SUB;
            else if (f7 == 7'b0100000 && f3 == 3'b101)
               ctrl.alu_sel = ALU_SRA;
            else if (f7 == 7'b0000001 && EN_MUL)
               ctrl.alu_sel = ALU_MUL + {2'b00, f3};
            else
               ctrl.illegal = 1'b1;
         end
         OPC_IMM: begin
            ctrl.imm_sel = IMM_I;
            ctrl.b_sel   = 1'b1;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.rd      = rd;
            // funct7 only qualifies the shifts; ADDI never becomes SUB.
            if (f3 == 3'b001)
               ctrl.illegal = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
               ctrl.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            ctrl.alu_sel = alu_base(f3, f3 == 3'b101 && f7 == 7'b0100000);
         end
         OPC_LOAD: begin
            ctrl.imm_sel = IMM_I;
            ctrl.b_sel   = 1'b1;
            ctrl.reg_wen = 1'b1;
            ctrl.mem_rd  = 1'b1;
            ctrl.wb_sel  = WB_MEM;
            ctrl.r_sel   = f3;
            ctrl.rd      = rd;
            ctrl.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            ctrl.imm_sel = IMM_S;
            ctrl.b_sel   = 1'b1;
            ctrl.mem_rw  = 1'b1;
            case (f3)
               3'd0:    ctrl.w_sel = W_SB;
               3'd1:    ctrl.w_sel = W_SH;
               3'd2:    ctrl.w_sel = W_SW;
               default: ctrl.illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            ctrl.imm_sel = IMM_U;
            ctrl.b_sel   = 1'b1;
            ctrl.alu_sel = ALU_PASSB;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.rd      = rd;
         end
         OPC_AUIPC: begin
            ctrl.imm_sel = IMM_U;
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b1;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.rd      = rd;
         end
         OPC_JAL: begin
            ctrl.imm_sel = IMM_J;
            ctrl.a_sel   = 1'b1;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.rd      = rd;
            ctrl.is_jal  = 1'b1;
         end
         OPC_JALR: begin
            ctrl.imm_sel = IMM_I;
            ctrl.reg_wen = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.rd      = rd;
            ctrl.is_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.imm_sel = IMM_B;
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b1;
            ctrl.br_un   = f3[2] & f3[1];  // BLTU / BGEU
            ctrl.is_br   = 1'b1;
            ctrl.funct3  = f3;
            ctrl.illegal = (f3[2:1] == 2'b01);
         end
         default: ctrl.illegal = 1'b1;
      endcase
      // An illegal instruction must have no architectural side effects.
      if (ctrl.illegal) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
      end
      if (rd == 5'd0)
         ctrl.reg_wen = 1'b0;
   end

endmodule

// File: rtl/rv_ctrl_pipe.sv
// rv_ctrl_pipe: ID/EX control register with valid/ready handshake,
// load-use stall and EX-stage branch/jump resolution.
//   clk, rst          clock, asynchronous active-high reset
//   id_valid/id_ready ID-side handshake, id_inst is the instruction word
//   ex_valid/ex_ready EX-side handshake, ex_* the registered control bundle
//   br_eq, br_lt      EX comparator results for the bundle in EX
//   pc_sel            redirect fetch to the branch/jump target
//   flush             wrong-path ID instruction is dropped this cycle
module rv_ctrl_pipe
   import rv_ctrl_pkg::*;
#(
   parameter bit EN_MUL    = 1'b0,
   parameter bit EN_HAZARD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_inst,
   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [2:0]  ex_imm_sel,
   output logic        ex_reg_wen,
   output logic        ex_br_un,
   output logic        ex_a_sel,
   output logic        ex_b_sel,
   output logic [4:0]  ex_alu_sel,
   output logic        ex_mem_rw,
   output logic        ex_mem_rd,
   output logic [1:0]  ex_wb_sel,
   output logic [2:0]  ex_r_sel,
   output logic [1:0]  ex_w_sel,
   output logic [4:0]  ex_rd,
   output logic        ex_illegal,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        pc_sel,
   output logic        flush
);

   ctrl_t      dec, ex_d, ex_q;
   logic       ex_valid_d, ex_valid_q;
   logic [4:0] id_rs1, id_rs2;
   logic       id_uses_rs2, hazard, ex_fire, br_taken;

   rv_ctrl_decode #(.EN_MUL(EN_MUL)) u_dec (
      .inst     (id_inst),
      .ctrl     (dec),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .uses_rs2 (id_uses_rs2)
   );

   always_comb begin
      hazard = EN_HAZARD && ex_valid_q && ex_q.mem_rd && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == id_rs1) || (id_uses_rs2 && ex_q.rd == id_rs2));

      case (ex_q.funct3)
         3'b000:         br_taken = br_eq;
         3'b001:         br_taken = !br_eq;
         3'b100, 3'b110: br_taken = br_lt;
         3'b101, 3'b111: br_taken = !br_lt;
         default:        br_taken = 1'b0;
      endcase

      pc_sel  = ex_valid_q && (ex_q.is_jal || ex_q.is_jalr || (ex_q.is_br && br_taken));
      flush   = pc_sel && ex_ready;
      ex_fire = !ex_valid_q || ex_ready;
      // During a flush ID is "accepted" only so the wrong-path word is dropped.
      id_ready = flush || (ex_fire && !hazard);

      ex_valid_d = ex_valid_q;
      ex_d       = ex_q;
      if (flush) begin
         ex_valid_d = 1'b0;
         ex_d       = '0;
      end else if (ex_fire) begin
         if (id_valid && !hazard) begin
            ex_valid_d = 1'b1;
            ex_d       = dec;
         end else begin
            // Empty ID or load-use bubble.
            ex_valid_d = 1'b0;
            ex_d       = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_q       <= ex_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_imm_sel = ex_q.imm_sel;
   assign ex_reg_wen = ex_q.reg_wen;
   assign ex_br_un   = ex_q.br_un;
   assign ex_a_sel   = ex_q.a_sel;
   assign ex_b_sel   = ex_q.b_sel;
   assign ex_alu_sel = ex_q.alu_sel;
   assign ex_mem_rw  = ex_q.mem_rw;
   assign ex_mem_rd  = ex_q.mem_rd;
   assign ex_wb_sel  = ex_q.wb_sel;
   assign ex_r_sel   = ex_q.r_sel;
   assign ex_w_sel   = ex_q.w_sel;
   assign ex_rd      = ex_q.rd;
   assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
module tb_rv_ctrl_pipe;

   logic clk = 1'b0, rst = 1'b1;
   logic id_valid = 1'b0, ex_ready = 1'b1, br_eq = 1'b0, br_lt = 1'b0;
   logic [31:0] id_inst = 32'h0;

   logic id_ready, ex_valid, ex_reg_wen, ex_br_un, ex_a_sel, ex_b_sel;
   logic ex_mem_rw, ex_mem_rd, ex_illegal, pc_sel, flush;
   logic [2:0] ex_imm_sel, ex_r_sel;
   logic [4:0] ex_alu_sel, ex_rd;
   logic [1:0] ex_wb_sel, ex_w_sel;

   logic id_ready_0, ex_valid_0, ex_reg_wen_0, ex_br_un_0, ex_a_sel_0, ex_b_sel_0;
   logic ex_mem_rw_0, ex_mem_rd_0, ex_illegal_0, pc_sel_0, flush_0;
   logic [2:0] ex_imm_sel_0, ex_r_sel_0;
   logic [4:0] ex_alu_sel_0, ex_rd_0;
   logic [1:0] ex_wb_sel_0, ex_w_sel_0;

   always #5 clk = ~clk;

   rv_ctrl_pipe #(.EN_MUL(1'b1), .EN_HAZARD(1'b1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_imm_sel(ex_imm_sel),
      .ex_reg_wen(ex_reg_wen), .ex_br_un(ex_br_un), .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel),
      .ex_alu_sel(ex_alu_sel), .ex_mem_rw(ex_mem_rw), .ex_mem_rd(ex_mem_rd),
      .ex_wb_sel(ex_wb_sel), .ex_r_sel(ex_r_sel), .ex_w_sel(ex_w_sel), .ex_rd(ex_rd),
      .ex_illegal(ex_illegal), .br_eq(br_eq), .br_lt(br_lt), .pc_sel(pc_sel), .flush(flush));

   rv_ctrl_pipe #(.EN_MUL(1'b0), .EN_HAZARD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready_0), .id_inst(id_inst),
      .ex_ready(ex_ready), .ex_valid(ex_valid_0), .ex_imm_sel(ex_imm_sel_0),
      .ex_reg_wen(ex_reg_wen_0), .ex_br_un(ex_br_un_0), .ex_a_sel(ex_a_sel_0),
      .ex_b_sel(ex_b_sel_0), .ex_alu_sel(ex_alu_sel_0), .ex_mem_rw(ex_mem_rw_0),
      .ex_mem_rd(ex_mem_rd_0), .ex_wb_sel(ex_wb_sel_0), .ex_r_sel(ex_r_sel_0),
      .ex_w_sel(ex_w_sel_0), .ex_rd(ex_rd_0), .ex_illegal(ex_illegal_0),
      .br_eq(br_eq), .br_lt(br_lt), .pc_sel(pc_sel_0), .flush(flush_0));

   typedef struct packed {
      logic [2:0] imm; logic wen; logic bun; logic asel; logic bsel; logic [4:0] alu;
      logic mrw; logic mrd; logic [1:0] wb; logic [2:0] rsel; logic [1:0] wsel;
      logic [4:0] rd; logic ill;
   } exp_t;
   typedef struct { string nm; logic [31:0] inst; exp_t e; } vec_t;
   typedef struct { string nm; exp_t e; } sb_t;

   exp_t act;
   assign act = {ex_imm_sel, ex_reg_wen, ex_br_un, ex_a_sel, ex_b_sel, ex_alu_sel,
                 ex_mem_rw, ex_mem_rd, ex_wb_sel, ex_r_sel, ex_w_sel, ex_rd, ex_illegal};

   sb_t  sb[$];
   vec_t vt[$];
   int   checks = 0, errors = 0;

   function automatic exp_t E(int imm, int wen, int bun, int asel, int bsel, int alu,
                              int mrw, int mrd, int wb, int rsel, int wsel, int rd, int ill);
      exp_t e;
      e.imm = 3'(imm); e.wen = 1'(wen); e.bun = 1'(bun); e.asel = 1'(asel);
      e.bsel = 1'(bsel); e.alu = 5'(alu); e.mrw = 1'(mrw); e.mrd = 1'(mrd);
      e.wb = 2'(wb); e.rsel = 3'(rsel); e.wsel = 2'(wsel); e.rd = 5'(rd); e.ill = 1'(ill);
      return e;
   endfunction

   function automatic vec_t V(string nm, logic [31:0] inst, exp_t e);
      vec_t v;
      v.nm = nm; v.inst = inst; v.e = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Scoreboard: a bundle is compared on the cycle EX consumes it.
   always begin
      sb_t s;
      @(negedge clk); #2;
      if (!rst && ex_valid && ex_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected bundle: got %h expected none", act);
         end else begin
            s = sb.pop_front();
            chk(s.nm, act, s.e);
         end
      end
   end

   task automatic send(input string nm, input logic [31:0] inst, input exp_t e);
      int n;
      @(negedge clk);
      id_valid = 1'b1; id_inst = inst;
      for (n = 0; n < 20; n++) begin
         #1;
         if (id_ready) begin
            @(posedge clk);
            sb.push_back('{nm, e});
            break;
         end
         @(negedge clk);
      end
      if (n == 20) begin
         checks++; errors++;
         $display("FAIL %s accept timeout: got id_ready=0 expected 1", nm);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      id_valid = 1'b0;
   endtask

   exp_t e_add6, e_sw, e_lui, e_mul;

   initial begin
      e_add6 = E(5,1,0,0,0, 0,0,0,1,0,0, 6,0);
      e_sw   = E(1,0,0,0,1, 0,1,0,0,0,0, 0,0);
      e_lui  = E(3,1,0,0,1,10,0,0,1,0,0, 7,0);
      e_mul  = E(5,1,0,0,0,16,0,0,1,0,0, 1,0);
      vt.push_back(V("add",    32'h002081B3, E(5,1,0,0,0, 0,0,0,1,0,0, 3,0)));
      vt.push_back(V("sub",    32'h40208233, E(5,1,0,0,0, 1,0,0,1,0,0, 4,0)));
      vt.push_back(V("sra",    32'h4020D2B3, E(5,1,0,0,0, 7,0,0,1,0,0, 5,0)));
      vt.push_back(V("nop",    32'h00000013, E(0,0,0,0,1, 0,0,0,1,0,0, 0,0)));
      vt.push_back(V("addi-1", 32'hFFF08393, E(0,1,0,0,1, 0,0,0,1,0,0, 7,0)));
      vt.push_back(V("srai",   32'h4030D413, E(0,1,0,0,1, 7,0,0,1,0,0, 8,0)));
      vt.push_back(V("sltiu",  32'h0050B493, E(0,1,0,0,1, 8,0,0,1,0,0, 9,0)));
      vt.push_back(V("lbu",    32'h0000C503, E(0,1,0,0,1, 0,0,1,0,4,0,10,0)));
      vt.push_back(V("ld ill", 32'h0000B583, E(0,0,0,0,0, 0,0,0,0,0,0, 0,1)));
      vt.push_back(V("sh",     32'h00209323, E(1,0,0,0,1, 0,1,0,0,0,1, 0,0)));
      vt.push_back(V("sd ill", 32'h0020B023, E(0,0,0,0,0, 0,0,0,0,0,0, 0,1)));
      vt.push_back(V("auipc",  32'h00001617, E(3,1,0,1,1, 0,0,0,1,0,0,12,0)));
      vt.push_back(V("beq nt", 32'h00208463, E(2,0,0,1,1, 0,0,0,0,0,0, 0,0)));
      vt.push_back(V("bltu nt",32'h0020E463, E(2,0,1,1,1, 0,0,0,0,0,0, 0,0)));
      vt.push_back(V("br f3=2",32'h0020A463, E(0,0,0,0,0, 0,0,0,0,0,0, 0,1)));
      vt.push_back(V("bad opc",32'hFFFFFFFF, E(0,0,0,0,0, 0,0,0,0,0,0, 0,1)));
      vt.push_back(V("low 00", 32'h002081B0, E(0,0,0,0,0, 0,0,0,0,0,0, 0,1)));
      vt.push_back(V("lui",    32'h123453B7, e_lui));
      vt.push_back(V("mul",    32'h023100B3, e_mul));
      vt.push_back(V("remu",   32'h023170B3, E(5,1,0,0,0,23,0,0,1,0,0, 1,0)));

      // Reset state
      #12;
      chk("rst ex_valid", ex_valid, 0);
      chk("rst bundle", act, 0);
      chk("rst pc_sel", pc_sel, 0);
      chk("rst flush", flush, 0);
      @(negedge clk); rst = 1'b0;

      // Decode table, back to back with EX always ready
      foreach (vt[i]) send(vt[i].nm, vt[i].inst, vt[i].e);
      idle();

      // M-extension disabled instance flags mul as illegal with no write
      send("mul", 32'h023100B3, e_mul);
      @(negedge clk); id_valid = 1'b0; #1;
      chk("nomul ex_valid", ex_valid_0, 1);
      chk("nomul illegal", ex_illegal_0, 1);
      chk("nomul reg_wen", ex_reg_wen_0, 0);

      // Load-use: one stall cycle, one bubble; no stall without hazard logic
      send("lw x5", 32'h0000A283, E(0,1,0,0,1,0,0,1,0,2,0,5,0));
      @(negedge clk); id_valid = 1'b1; id_inst = 32'h00228333; #1;
      chk("lu stall id_ready", id_ready, 0);
      chk("lu nohaz id_ready", id_ready_0, 1);
      @(posedge clk); #1;
      chk("lu bubble ex_valid", ex_valid, 0);
      chk("lu nohaz ex_rd", {ex_valid_0, 3'b0, ex_rd_0}, {1'b1, 3'b0, 5'd6});
      @(negedge clk); #1;
      chk("lu resume id_ready", id_ready, 1);
      @(posedge clk); sb.push_back('{"add x6", e_add6});
      idle();

      // Taken bltu flushes the next ID instruction
      br_lt = 1'b1;
      send("bltu t", 32'h0020E463, E(2,0,1,1,1,0,0,0,0,0,0,0,0));
      @(negedge clk); id_valid = 1'b1; id_inst = 32'h00100493; #1;
      chk("bltu pc_sel", pc_sel, 1);
      chk("bltu flush", flush, 1);
      chk("bltu id_ready", id_ready, 1);
      @(posedge clk); #1;
      chk("flushed ex_valid", ex_valid, 0);
      br_lt = 1'b0;
      send("blt nt", 32'h0020C463, E(2,0,0,1,1,0,0,0,0,0,0,0,0));
      @(negedge clk); id_valid = 1'b0; #1;
      chk("blt pc_sel", pc_sel, 0);
      chk("blt flush", flush, 0);

      // EX back-pressure holds sw for three cycles
      idle();
      @(negedge clk); ex_ready = 1'b0; id_valid = 1'b1; id_inst = 32'h00112223; #1;
      chk("sw id_ready", id_ready, 1);
      @(posedge clk); sb.push_back('{"sw", e_sw});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); id_inst = 32'h123453B7; #1;
         chk("hold bundle", act, e_sw);
         chk("hold ex_valid", ex_valid, 1);
         chk("hold id_ready", id_ready, 0);
      end
      @(negedge clk); ex_ready = 1'b1; #1;
      chk("release id_ready", id_ready, 1);
      @(posedge clk); sb.push_back('{"lui", e_lui});
      idle();

      // Asynchronous reset with a jump in EX
      send("jal", 32'h008000EF, E(4,1,0,1,0,0,0,0,2,0,0,1,0));
      @(negedge clk); id_valid = 1'b0; #1;
      chk("jal pc_sel", pc_sel, 1);
      chk("jal ex_valid", ex_valid, 1);
      #2 rst = 1'b1; #1;
      chk("arst ex_valid", ex_valid, 0);
      chk("arst pc_sel", pc_sel, 0);
      chk("arst flush", flush, 0);
      chk("arst bundle", act, 0);
      @(posedge clk); @(negedge clk); rst = 1'b0;

      repeat (3) @(posedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
